// File: rtl/mmio_uart_tx_if.sv
// rtl/mmio_uart_tx_if.sv - core data-memory bus bundle seen by the console UART
interface mmio_uart_tx_if;
   logic [31:0] address;
   logic [31:0] write_data;
   logic        memwrite;
   logic        memread;
   logic        hit;
   logic [31:0] read_data;

   modport master (
      output address,
      output write_data,
      output memwrite,
      output memread,
      input  hit,
      input  read_data
   );

   modport slave (
      input  address,
      input  write_data,
      input  memwrite,
      input  memread,
      output hit,
      output read_data
   );
endinterface

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped byte FIFO draining into an 8N1 UART transmitter
// Optional even-parity bit: define MMIO_UART_TX_PARITY_EN.
module mmio_uart_tx #(
   parameter logic [31:0] BASE_ADDR    = 32'hFFFF0000,
   parameter int          CLKS_PER_BIT = 16,
   parameter int          FIFO_DEPTH   = 8
) (
   input  logic          clock,
   input  logic          reset,
   mmio_uart_tx_if.slave bus,
   output logic          tx,
   output logic          busy
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int BAUD_W = $clog2(CLKS_PER_BIT);

   localparam logic [31:0]       STATUS_ADDR = BASE_ADDR + 32'd4;
   localparam logic [BAUD_W-1:0] BAUD_LAST   = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  DEPTH_C     = CNT_W'(FIFO_DEPTH);

`ifdef MMIO_UART_TX_PARITY_EN
   localparam logic PARITY_CAP = 1'b1;
`else
   localparam logic PARITY_CAP = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef MMIO_UART_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   logic [7:0]        r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic              r_overflow;

   state_t            r_state;
   state_t            w_state_next;
   logic [BAUD_W-1:0] r_baud;
   logic [BAUD_W-1:0] w_baud_next;
   logic [2:0]        r_bit_idx;
   logic [2:0]        w_bit_next;
   logic [7:0]        r_shift;
   logic [7:0]        w_shift_next;
   logic              r_tx;
   logic              w_tx_next;
`ifdef MMIO_UART_TX_PARITY_EN
   logic              r_parity;
`endif

   logic              w_sel_data;
   logic              w_sel_status;
   logic              w_push;
   logic              w_pop;
   logic              w_accept;
   logic              w_drop;
   logic              w_ovf_clr;
   logic              w_fifo_empty;
   logic              w_full;
   logic              w_status_empty;
   logic              w_baud_done;
   logic [7:0]        w_head;
   logic [31:0]       w_status;
   logic              w_unused;

   assign w_sel_data   = (bus.address == BASE_ADDR);
   assign w_sel_status = (bus.address == STATUS_ADDR);
   assign w_fifo_empty = (r_count == '0);
   assign w_full       = (r_count == DEPTH_C);
   assign w_head       = r_mem[r_rd_ptr];
   assign w_baud_done  = (r_baud == BAUD_LAST);

   // A full FIFO still takes a store when the serialiser frees a slot on the same edge.
   assign w_push   = bus.memwrite && w_sel_data;
   assign w_pop    = (r_state == S_IDLE) && !w_fifo_empty;
   assign w_accept = w_push && (!w_full || w_pop);
   assign w_drop   = w_push && !w_accept;
   assign w_ovf_clr = bus.memread && w_sel_status;

   assign w_status_empty = w_fifo_empty && (r_state == S_IDLE);
   assign w_status       = {28'd0, PARITY_CAP, r_overflow, w_full, w_status_empty};

   assign bus.hit       = (bus.memread || bus.memwrite) && (w_sel_data || w_sel_status);
   assign bus.read_data = (bus.memread && w_sel_status) ? w_status : 32'd0;

   assign tx   = r_tx;
   assign busy = !w_fifo_empty || (r_state != S_IDLE);

   assign w_unused = ^bus.write_data[31:8];

   always_ff @(posedge clock) begin
      if (w_accept) begin
         r_mem[r_wr_ptr] <= bus.write_data[7:0];
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_accept) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         if (w_accept && !w_pop) begin
            r_count <= r_count + CNT_W'(1);
         end else if (w_pop && !w_accept) begin
            r_count <= r_count - CNT_W'(1);
         end
         if (w_drop) begin
            r_overflow <= 1'b1;
         end else if (w_ovf_clr) begin
            r_overflow <= 1'b0;
         end
      end
   end

   // tx is registered from the next-state value so the line changes exactly on state edges.
   always_comb begin
      w_state_next = r_state;
      w_baud_next  = r_baud;
      w_bit_next   = r_bit_idx;
      w_shift_next = r_shift;
      w_tx_next    = 1'b1;
      case (r_state)
         S_IDLE: begin
            w_baud_next = '0;
            if (w_pop) begin
               w_state_next = S_START;
               w_shift_next = w_head;
               w_tx_next    = 1'b0;
            end
         end
         S_START: begin
            w_tx_next = 1'b0;
            if (w_baud_done) begin
               w_state_next = S_DATA;
               w_baud_next  = '0;
               w_bit_next   = '0;
               w_tx_next    = r_shift[0];
            end else begin
               w_baud_next = r_baud + BAUD_W'(1);
            end
         end
         S_DATA: begin
            w_tx_next = r_shift[0];
            if (w_baud_done) begin
               w_baud_next = '0;
               if (r_bit_idx == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
                  w_state_next = S_PARITY;
                  w_tx_next    = r_parity;
`else
                  w_state_next = S_STOP;
                  w_tx_next    = 1'b1;
`endif
               end else begin
                  w_shift_next = {1'b0, r_shift[7:1]};
                  w_bit_next   = r_bit_idx + 3'd1;
                  w_tx_next    = r_shift[1];
               end
            end else begin
               w_baud_next = r_baud + BAUD_W'(1);
            end
         end
`ifdef MMIO_UART_TX_PARITY_EN
         S_PARITY: begin
            w_tx_next = r_parity;
            if (w_baud_done) begin
               w_state_next = S_STOP;
               w_baud_next  = '0;
               w_tx_next    = 1'b1;
            end else begin
               w_baud_next = r_baud + BAUD_W'(1);
            end
         end
`endif
         S_STOP: begin
            w_tx_next = 1'b1;
            if (w_baud_done) begin
               w_state_next = S_IDLE;
               w_baud_next  = '0;
            end else begin
               w_baud_next = r_baud + BAUD_W'(1);
            end
         end
         default: begin
            w_state_next = S_IDLE;
            w_baud_next  = '0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_baud    <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_tx      <= 1'b1;
      end else begin
         r_state   <= w_state_next;
         r_baud    <= w_baud_next;
         r_bit_idx <= w_bit_next;
         r_shift   <= w_shift_next;
         r_tx      <= w_tx_next;
      end
   end

`ifdef MMIO_UART_TX_PARITY_EN
   // The shift register is consumed during DATA, so the parity of the popped byte is kept aside.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_parity <= 1'b0;
      end else if (w_pop) begin
         r_parity <= ^w_head;
      end
   end
`endif

endmodule
